hazard_stall_ctrl: RTL

//  Pipeline sequencing controller for the 5-stage CPU. Drives the IF/ID register's stall and

---
 rtl/hazard_stall_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing: load-use stalls, branch/exception flushes,
// and front-end hold while the multi-cycle MUL/DIV unit runs.
module hazard_stall_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              ex_is_load,
    input  logic [4:0]        ex_rd,
    input  logic              id_branch_taken,
    input  logic              id_mdu_start,
    input  logic              id_mdu_is_div,
    input  logic              exc_flush,
    output logic              pc_stall,
    output logic              if_id_stall,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              mdu_busy,
    output logic              mdu_done,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lu_haz;
    logic             start_acc;
    logic             stall_any;

    assign lu_haz = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_uses_rs && (id_rs == ex_rd)) ||
                     (id_uses_rt && (id_rt == ex_rd)));

    assign start_acc = (state == IDLE) && id_mdu_start &&
                       !lu_haz && !exc_flush;

    assign stall_any = lu_haz || start_acc || (state == BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (exc_flush) begin
            // Redirect aborts any MDU op in flight.
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_acc) begin
                        state_nxt = BUSY;
                        cnt_nxt   = id_mdu_is_div ? CNT_W'(DIV_CYCLES - 1)
                                                  : CNT_W'(MUL_CYCLES - 1);
                    end
                end
                BUSY: begin
                    if (cnt == CNT_W'(1)) state_nxt = DONE;
                    else                  cnt_nxt   = cnt - CNT_W'(1);
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        pc_stall     = stall_any;
        if_id_stall  = stall_any;
        id_ex_bubble = stall_any;
        if_id_flush  = id_branch_taken && !stall_any;
        mdu_busy     = (state == BUSY);
        mdu_done     = (state == DONE) && !exc_flush;
        if (exc_flush) begin
            pc_stall     = 1'b0;
            if_id_stall  = 1'b0;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cycles <= '0;
        else if (pc_stall && !(&stall_cycles))
            stall_cycles <= stall_cycles + PERF_W'(1);
    end

endmodule
